// File: rtl/gfx_cmd_pkg.sv
// Shared command-stream definitions: header field positions, opcodes, fetch states
// and the beat descriptor carried between the sequencer and its output register.
package gfx_cmd_pkg;
  localparam int HDR_PAY_BIT = 31;
  localparam int CNT_MSB     = 15;
  localparam int CNT_LSB     = 8;
  localparam int OP_MSB      = 7;
  localparam int OP_LSB      = 0;

  localparam logic [7:0] OP_VERTEX = 8'h03;
  localparam logic [7:0] OP_COLOR  = 8'h04;
  localparam logic [7:0] OP_FLUSH  = 8'h05;
  localparam logic [7:0] OP_JUMP   = 8'h06;
  localparam logic [7:0] OP_MATRIX = 8'h16;

  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 32;

  typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_PAY, ST_HALT} fetch_state_e;

  typedef struct packed {
    logic [7:0] op;
    logic [7:0] cnt;
    logic       first;
    logic       last;
    logic [2:0] nwords;
  } beat_hdr_t;
endpackage

// File: rtl/cmd_beat_reg.sv
// Output beat register: loads only when empty or being drained, holds while stalled,
// zeroes lanes at or above nwords.
module cmd_beat_reg
  import gfx_cmd_pkg::*;
#(
  parameter int NUM_LANES = 4,
  parameter int VEC_W     = 32
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                load,
  input  beat_hdr_t                           hdr_in,
  input  logic [NUM_LANES-1:0][VEC_W-1:0]     lanes_in,
  input  logic                                ready,
  output logic                                valid,
  output logic                                free,
  output beat_hdr_t                           hdr_q,
  output logic [NUM_LANES-1:0][VEC_W-1:0]     lanes_q
);
  logic [NUM_LANES-1:0][VEC_W-1:0] masked;

  assign free = !valid || ready;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign masked[i] = (32'(hdr_in.nwords) > i) ? lanes_in[i] : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid   <= 1'b0;
      hdr_q   <= '0;
      lanes_q <= '0;
    end else if (free) begin
      valid <= load;
      if (load) begin
        hdr_q   <= hdr_in;
        lanes_q <= masked;
      end
    end
  end
endmodule

// File: rtl/cmd_fetch.sv
// Command-stream fetch/sequencer between instruction BRAM and geometry pipeline.
// Optional CMD_FETCH_STATS_EN adds stat_cmds / stat_stalls counters.
module cmd_fetch
  import gfx_cmd_pkg::*;
#(
  parameter int          MEM_DEPTH   = 384,
  parameter int          MAX_PAYLOAD = 16,
  parameter logic [31:0] START_ADDR  = 32'd0,
  parameter logic [7:0]  JUMP_OP     = OP_JUMP
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  output logic [31:0] addr1,
  output logic [31:0] addr2,
  input  logic [31:0] read0,
  input  logic [31:0] read1,
  input  logic [31:0] read2,
  input  logic [31:0] read3,
  input  logic [31:0] read4,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_op,
  output logic [7:0]  out_cnt,
  output logic        out_first,
  output logic        out_last,
  output logic [2:0]  out_nwords,
  output logic [31:0] out_d0,
  output logic [31:0] out_d1,
  output logic [31:0] out_d2,
  output logic [31:0] out_d3,
`ifdef CMD_FETCH_STATS_EN
  output logic [31:0] stat_cmds,
  output logic [31:0] stat_stalls,
`endif
  output logic        busy,
  output logic        fault,
  output logic [31:0] pc
);
  localparam logic [7:0]  MAX_P = 8'(MAX_PAYLOAD);
  localparam logic [32:0] DEPTH = 33'(MEM_DEPTH);

  fetch_state_e state, state_n;
  logic [31:0]  pc_n;
  logic [7:0]   rem, rem_n, op_q, op_n, cnt_q, cnt_n;
  logic         fault_n, load, free;
  beat_hdr_t    b_hdr, hdr_q;
  logic [NUM_LANES-1:0][VEC_W-1:0] lanes_q;

  logic [7:0]   hop, hcnt;
  logic [32:0]  hend;
  logic [31:0]  jtgt;
  logic [2:0]   pay_n;

  assign hop   = read0[OP_MSB:OP_LSB];
  assign hcnt  = read0[HDR_PAY_BIT] ? read0[CNT_MSB:CNT_LSB] : 8'd0;
  assign hend  = {1'b0, pc} + 33'd1 + {25'd0, hcnt};
  assign jtgt  = read0[HDR_PAY_BIT] ? read1 : 32'd0;
  assign pay_n = (rem >= 8'd4) ? 3'd4 : rem[2:0];

  assign addr1 = pc;
  assign addr2 = (state == ST_FETCH) ? pc + 32'd1 : pc;
  assign busy  = (state != ST_IDLE) || out_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      pc    <= START_ADDR;
      rem   <= '0;
      op_q  <= '0;
      cnt_q <= '0;
      fault <= 1'b0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      rem   <= rem_n;
      op_q  <= op_n;
      cnt_q <= cnt_n;
      fault <= fault_n;
    end
  end

  always_comb begin
    state_n = state;
    pc_n    = pc;
    rem_n   = rem;
    op_n    = op_q;
    cnt_n   = cnt_q;
    fault_n = fault;
    load    = 1'b0;
    b_hdr   = '{op: op_q, cnt: cnt_q, first: 1'b0, last: 1'b0, nwords: 3'd0};
    unique case (state)
      ST_IDLE: if (run && !fault) state_n = ST_FETCH;
      ST_FETCH: begin
        if (hcnt > MAX_P || hend > DEPTH) begin
          fault_n = 1'b1;
          state_n = ST_HALT;
        end else if (hop == JUMP_OP) begin
          pc_n = jtgt;
          if (33'(jtgt) >= DEPTH) begin
            fault_n = 1'b1;
            state_n = ST_HALT;
          end else begin
            state_n = run ? ST_FETCH : ST_IDLE;
          end
        end else if (hcnt == 8'd0) begin
          // zero-payload commands wait in FETCH until the output register can take them
          if (free) begin
            load    = 1'b1;
            b_hdr   = '{op: hop, cnt: 8'd0, first: 1'b1, last: 1'b1, nwords: 3'd0};
            pc_n    = pc + 32'd1;
            state_n = run ? ST_FETCH : ST_IDLE;
          end
        end else begin
          op_n    = hop;
          cnt_n   = hcnt;
          rem_n   = hcnt;
          pc_n    = pc + 32'd1;
          state_n = ST_PAY;
        end
      end
      ST_PAY: begin
        if (free) begin
          load    = 1'b1;
          b_hdr   = '{op: op_q, cnt: cnt_q, first: (rem == cnt_q),
                      last: (rem <= 8'd4), nwords: pay_n};
          pc_n    = pc + 32'(pay_n);
          rem_n   = rem - 8'(pay_n);
          if (rem <= 8'd4) state_n = run ? ST_FETCH : ST_IDLE;
        end
      end
      default: ;
    endcase
  end

  cmd_beat_reg #(.NUM_LANES(NUM_LANES), .VEC_W(VEC_W)) u_beat (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .hdr_in   (b_hdr),
    .lanes_in ({read4, read3, read2, read1}),
    .ready    (out_ready),
    .valid    (out_valid),
    .free     (free),
    .hdr_q    (hdr_q),
    .lanes_q  (lanes_q)
  );

  assign out_op     = hdr_q.op;
  assign out_cnt    = hdr_q.cnt;
  assign out_first  = hdr_q.first;
  assign out_last   = hdr_q.last;
  assign out_nwords = hdr_q.nwords;
  assign out_d0     = lanes_q[0];
  assign out_d1     = lanes_q[1];
  assign out_d2     = lanes_q[2];
  assign out_d3     = lanes_q[3];

`ifdef CMD_FETCH_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_cmds   <= '0;
      stat_stalls <= '0;
    end else begin
      if (out_valid && out_ready && out_last) stat_cmds <= stat_cmds + 32'd1;
      if (out_valid && !out_ready) stat_stalls <= stat_stalls + 32'd1;
    end
  end
`endif
endmodule

// File: doc/cmd_fetch.md
Name: cmd_fetch

Overview:
- Command-stream fetch/sequencer directly downstream of the instruction BRAM.
- Drives the BRAM's two async read addresses:
  - one for the header word;
  - one base for four consecutive payload words.
- Parses headers: bit31 = payload present, [15:8] = payload word count, [7:0] = opcode.
- Streams each command to the geometry pipeline as 4-word beats over a valid/ready handshake.
- Handles Jump internally; Flush is forwarded as a zero-payload command.

Parameters:
- MEM_DEPTH, 384, number of 32-bit words in the instruction BRAM; fetch must stay below this.
- MAX_PAYLOAD, 16, largest legal payload word count (a 4x4 matrix).
- START_ADDR, 0, PC value after reset.
- OP_JUMP, 8'h06, opcode consumed internally.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- run  in  1  fetch enable, sampled only at command boundaries
- addr1  out  32  header read address to BRAM
- addr2  out  32  payload base read address to BRAM
- read0  in  32  mem[addr1], combinational
- read1..read4  in  32 each  mem[addr2..addr2+3], combinational
- out_valid  out  1  beat valid
- out_ready  in  1  downstream accepts beat
- out_op  out  8  opcode of current command
- out_cnt  out  8  total payload words of current command
- out_first  out  1  first beat of command
- out_last  out  1  last beat of command
- out_nwords  out  3  valid words in beat, 0..4
- out_d0..out_d3  out  32 each  payload words, unused lanes zero
- busy  out  1  state != IDLE or out_valid
- fault  out  1  sticky error flag
- pc  out  32  current fetch address

Behaviour:
- Reset (async, rst=0): state=IDLE, pc=START_ADDR, all out_* = 0, fault=0, busy=0.
- Addressing: addr1 = pc at all times. addr2 = pc+1 in FETCH, pc in PAY.
- Output register update: loads only when !out_valid || out_ready. Fields hold stable while out_valid && !out_ready.

States:
- IDLE: if run && !fault, go to FETCH.
- FETCH (header at read0):
  - Payload count = bit31 ? [15:8] : 0.
  - If count > MAX_PAYLOAD, or pc+1+count > MEM_DEPTH: fault=1, go to HALT. No beat is emitted.
  - Opcode == OP_JUMP:
    - pc <= bit31 ? read1 : 0.
    - If the target is >= MEM_DEPTH: fault.
    - Otherwise go to FETCH if run, else IDLE. No beat is emitted; the jump takes 1 cycle.
  - Other opcode with count 0: when the output register is free, emit one beat (first=last=1, nwords=0); pc <= pc+1; next state FETCH/IDLE per run. If the register is not free, stay in FETCH.
  - Other opcode with count > 0: latch op and count; rem <= count; pc <= pc+1; go to PAY.
- PAY: when the output register is free:
  - Load beat n = min(4, rem) from read1..read(n); zero the other lanes.
  - first = (rem == count); last = (rem <= 4).
  - pc += n; rem -= n.
  - If last: go to FETCH if run, else IDLE.
- HALT: terminal until reset. out_valid deasserts after any pending beat is accepted.

Timing and rules:
- Latency: header in FETCH at cycle N; first beat out_valid at N+2. With out_ready held high, one beat per cycle and one extra cycle per header.
- Opcode 0 (null word) is treated as an ordinary zero-payload command.
- Deasserting run mid-command finishes the command first.
- pc arithmetic is 32-bit.
- BRAM writes during fetch are not interlocked; software updates memory only while busy=0.

Optional Feature:
- Macro CMD_FETCH_STATS_EN.
- With it: adds outputs stat_cmds[31:0] and stat_stalls[31:0].
  - stat_cmds increments on each accepted beat with out_last=1.
  - stat_stalls increments each cycle with out_valid && !out_ready.
  - Both cleared by reset and wrap at 2^32.
- Without it: these ports and counters do not exist. All other behaviour is identical.

Decomposition:
- Shared package gfx_cmd_pkg:
  - header field positions (HDR_PAY_BIT=31, CNT_MSB/LSB=15/8, OP_MSB/LSB=7:0);
  - opcode constants OP_VERTEX=8'h03, OP_COLOR=8'h04, OP_FLUSH=8'h05, OP_JUMP=8'h06, OP_MATRIX=8'h16;
  - state encoding typedef.
- Sub-module cmd_beat_reg: output register with valid/ready hold and lane masking by nwords.

Test Plan:
- Header 32'h80000304 then 3F800000, 0, 0, out_ready=1 → one beat: op=04, cnt=3, nwords=3, first=last=1, d0=3F800000, d3=0, valid at N+2; pc advances by 4.
- Header 32'h80001016 plus 16 words → 4 beats, nwords=4 each, first only on beat 1, last only on beat 4; out_ready toggling 1/0 holds beat data stable with no loss.
- Stream 00000005, 00000006, 0 → Flush beat (op=05, nwords=0); the Jump emits nothing and sets pc=0; fetch restarts at address 0.
- Header 32'h80001104 (count 17) → fault=1, no beat, state HALT; assert rst=0 mid-HALT → all outputs 0, pc=0 immediately.
- Header 32'h80000303 at pc=382 → pc+1+3 > 384 → fault. Separately, run=0 during a 16-word command → command completes, then IDLE, busy=0.
- With CMD_FETCH_STATS_EN: 3 commands with 5 stall cycles → stat_cmds=3, stat_stalls=5.
